// File: rtl/weight_init_ctrl.sv
// -----------------------------------------------------------------------------
// weight_init_ctrl
//   Sequencer and single-port arbiter for the weight RAM. A start pulse fills
//   addresses 0..DEPTH-1 with pseudo-random signed weights from a 10-bit
//   Fibonacci LFSR, one word per cycle. After the fill completes, the RAM
//   port is granted to the inference datapath for pipelined reads.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   start        : one-cycle request to (re)run the fill (IDLE or READY only)
//   rd_req       : inference read request, rd_addr sampled with it
//   rd_gnt       : combinational accept of rd_req this cycle
//   rd_valid     : registered, rd_data valid this cycle
//   rd_data      : read data, passed straight from ram_rdata
//   ram_addr     : registered RAM address
//   ram_wdata    : registered RAM write data
//   ram_we       : registered RAM write enable
//   ram_re       : registered RAM read enable
//   ram_rdata    : synchronous RAM read data (one cycle after ram_re)
//   busy         : high while filling
//   done         : high while the port belongs to the read path
//   fill_count   : words written in the current/last fill
// -----------------------------------------------------------------------------
module weight_init_ctrl #(
    parameter int         DEPTH  = 65,
    parameter int         ADDR_W = 7,
    parameter int         DATA_W = 10,
    parameter logic [9:0] SEED   = 10'h001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   fill_count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t     state;
    logic [9:0] lfsr;

    // x^10 + x^7 + 1, maximal length 1023
    function automatic logic [9:0] lfsr_next(input logic [9:0] q);
        return {q[8:0], q[9] ^ q[6]};
    endfunction

    // Narrow by taking low bits, widen by replicating the 10-bit pattern
    function automatic logic [DATA_W-1:0] lfsr_word(input logic [9:0] q);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w[i] = q[i % 10];
        end
        return w;
    endfunction

    // start has priority: a read asked for in the same cycle is refused
    assign rd_gnt  = (state == READY) && rd_req && !start;
    assign rd_data = ram_rdata;

    // Control FSM, LFSR, fill counter and registered RAM port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            fill_count <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Read pipeline: port cycle followed by data cycle
            rd_valid <= ram_re;
            case (state)
                FILL: begin
                    ram_re <= 1'b0;
                    if (fill_count == DEPTH_C) begin
                        state  <= READY;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        ram_we <= 1'b0;
                    end else begin
                        ram_we     <= 1'b1;
                        ram_addr   <= fill_count[ADDR_W-1:0];
                        ram_wdata  <= lfsr_word(lfsr);
                        lfsr       <= lfsr_next(lfsr);
                        fill_count <= fill_count + ONE_C;
                    end
                end
                IDLE, READY: begin
                    if (start) begin
                        // The edge accepting start already registers word 0,
                        // so the LFSR carries on from wherever it stopped.
                        state      <= FILL;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        ram_we     <= 1'b1;
                        ram_re     <= 1'b0;
                        ram_addr   <= '0;
                        ram_wdata  <= lfsr_word(lfsr);
                        lfsr       <= lfsr_next(lfsr);
                        fill_count <= ONE_C;
                    end else if (rd_gnt) begin
                        ram_we   <= 1'b0;
                        ram_re   <= 1'b1;
                        ram_addr <= rd_addr;
                    end else begin
                        ram_we <= 1'b0;
                        ram_re <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ram_we <= 1'b0;
                    ram_re <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_init_ctrl.sv
module tb_weight_init_ctrl;

    localparam int DEPTH  = 65;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   fill_count;

    int pass_count;
    int check_count;

    // Reference model: expected RAM contents and expected LFSR value
    logic [9:0] model_mem [0:127];
    logic [9:0] exp_lfsr;

    // Physical RAM seen by the DUT
    logic [9:0] ram_mem [0:127];

    weight_init_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(10'h001)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy(busy), .done(done), .fill_count(fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram_mem[ram_addr];
    end

    // Polynomial x^10+x^7+1 stepped with plain arithmetic
    function automatic logic [9:0] model_next(input logic [9:0] q);
        int v;
        v = int'(q);
        return 10'(((v * 2) % 1024) + (((v / 512) + ((v / 64) % 2)) % 2));
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rd_req = 1'b1; rd_addr = 7'd3;
        repeat (2) @(posedge clk);
        #2;
        check_count++;
        if ({ram_we, ram_re, rd_valid, busy, done} !== 5'b0) $display("FAIL reset_flags: got %b required 00000", {ram_we, ram_re, rd_valid, busy, done});
        else pass_count++;
        check_count++;
        if (ram_addr !== 7'd0 || ram_wdata !== 10'd0 || fill_count !== 8'd0) $display("FAIL reset_values: got addr=%h wdata=%h cnt=%0d required 0", ram_addr, ram_wdata, fill_count);
        else pass_count++;
        rst = 1'b0;
        @(posedge clk); #1;
        check_count++;
        if (rd_gnt !== 1'b0 || busy !== 1'b0) $display("FAIL idle_no_gnt: got gnt=%b busy=%b required 0 0", rd_gnt, busy);
        else pass_count++;
        rd_req = 1'b0;
    endtask

    // Pulse start and follow the whole fill; optionally with noise inputs,
    // a read request on the start cycle, or a read granted just before start.
    task automatic test_fill(input bit noisy, input bit req_at_start, input bit pending, input logic [9:0] pend_data);
        start = 1'b1; rd_req = req_at_start; rd_addr = 7'($urandom_range(0, 64));
        #1;
        check_count++;
        if (rd_gnt !== 1'b0) $display("FAIL start_gnt: got %b required 0", rd_gnt);
        else pass_count++;
        check_count++;
        if (ram_re !== pending || ram_we !== 1'b0) $display("FAIL start_port: got re=%b we=%b required re=%b we=0", ram_re, ram_we, pending);
        else pass_count++;
        @(posedge clk); #1;
        start = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1)); rd_req = 1'($urandom_range(0, 1)); rd_addr = 7'($urandom);
            end
            #1;
            check_count++;
            if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 7'(i) || ram_wdata !== exp_lfsr)
                $display("FAIL fill_write[%0d]: got we=%b re=%b addr=%0d wdata=%h required we=1 re=0 addr=%0d wdata=%h", i, ram_we, ram_re, ram_addr, ram_wdata, i, exp_lfsr);
            else pass_count++;
            check_count++;
            if (busy !== 1'b1 || done !== 1'b0 || rd_gnt !== 1'b0) $display("FAIL fill_status[%0d]: got busy=%b done=%b gnt=%b required 1 0 0", i, busy, done, rd_gnt);
            else pass_count++;
            check_count++;
            if (rd_valid !== (pending && i == 0)) $display("FAIL fill_rd_valid[%0d]: got %b required %b", i, rd_valid, pending && i == 0);
            else pass_count++;
            if (pending && i == 0) begin
                check_count++;
                if (rd_data !== pend_data) $display("FAIL pending_rd_data: got %h required %h", rd_data, pend_data);
                else pass_count++;
            end
            model_mem[i] = exp_lfsr;
            exp_lfsr = model_next(exp_lfsr);
            @(posedge clk); #1;
        end
        start = 1'b0; rd_req = 1'b0;
        #1;
        check_count++;
        if (done !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0 || fill_count !== 8'(DEPTH))
            $display("FAIL fill_end: got done=%b busy=%b we=%b cnt=%0d required 1 0 0 %0d", done, busy, ram_we, fill_count, DEPTH);
        else pass_count++;
    endtask

    // Directed reads 0,1,7 then random back-to-back reads against the model
    task automatic test_reads(input int n);
        bit               pv1, pv2;
        logic [ADDR_W-1:0] pa1, pa2;
        pv1 = 1'b0; pv2 = 1'b0; pa1 = '0; pa2 = '0;
        for (int t = 0; t < n + 4; t++) begin
            bit                req_b;
            logic [ADDR_W-1:0] a_v;
            if (t < 3) begin
                req_b = 1'b1;
                a_v = (t == 0) ? 7'd0 : (t == 1) ? 7'd1 : 7'd7;
            end else if (t < n) begin
                req_b = ($urandom_range(0, 3) != 0);
                a_v = 7'($urandom_range(0, 127));
            end else begin
                req_b = 1'b0;
                a_v = 7'd0;
            end
            rd_req = req_b; rd_addr = a_v;
            #1;
            check_count++;
            if (rd_gnt !== req_b) $display("FAIL read_gnt[%0d]: got %b required %b", t, rd_gnt, req_b);
            else pass_count++;
            check_count++;
            if (ram_re !== pv1 || ram_we !== 1'b0 || done !== 1'b1 || (pv1 && ram_addr !== pa1))
                $display("FAIL read_port[%0d]: got re=%b we=%b done=%b addr=%0d required re=%b we=0 done=1 addr=%0d", t, ram_re, ram_we, done, ram_addr, pv1, pa1);
            else pass_count++;
            check_count++;
            if (rd_valid !== pv2) $display("FAIL read_valid[%0d]: got %b required %b", t, rd_valid, pv2);
            else pass_count++;
            if (pv2 && int'(pa2) < DEPTH) begin
                check_count++;
                if (rd_data !== model_mem[pa2]) $display("FAIL read_data[%0d]: addr %0d got %h required %h", t, pa2, rd_data, model_mem[pa2]);
                else pass_count++;
            end
            pv2 = pv1; pa2 = pa1; pv1 = req_b; pa1 = a_v;
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
    endtask

    // Read granted the cycle before start completes during the first fill write
    task automatic test_read_then_start();
        logic [ADDR_W-1:0] a_v;
        logic [9:0]        d_v;
        a_v = 7'($urandom_range(0, DEPTH - 1));
        d_v = model_mem[a_v];
        rd_req = 1'b1; rd_addr = a_v;
        #1;
        check_count++;
        if (rd_gnt !== 1'b1) $display("FAIL pre_start_gnt: got %b required 1", rd_gnt);
        else pass_count++;
        @(posedge clk); #1;
        rd_req = 1'b0;
        test_fill(1'b0, 1'b0, 1'b1, d_v);
    endtask

    // Reset while the fill is at address 30
    task automatic test_reset_mid_fill();
        bit found;
        found = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (ram_we === 1'b1 && ram_addr === 7'd30) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check_count++;
        if (!found) $display("FAIL reach_addr30: got addr=%0d required 30 within 100 cycles", ram_addr);
        else pass_count++;
        rst = 1'b1; rd_req = 1'b1;
        #1;
        check_count++;
        if ({ram_we, ram_re, rd_valid, busy, done, rd_gnt} !== 6'b0) $display("FAIL midfill_reset_flags: got %b required 000000", {ram_we, ram_re, rd_valid, busy, done, rd_gnt});
        else pass_count++;
        check_count++;
        if (ram_addr !== 7'd0 || ram_wdata !== 10'd0 || fill_count !== 8'd0) $display("FAIL midfill_reset_values: got addr=%h wdata=%h cnt=%0d required 0", ram_addr, ram_wdata, fill_count);
        else pass_count++;
        @(posedge clk); #1;
        rst = 1'b0; rd_req = 1'b0;
        exp_lfsr = 10'h001;
        @(posedge clk); #1;
    endtask

    initial begin
        pass_count = 0; check_count = 0;
        exp_lfsr = 10'h001;
        ram_rdata = '0;
        for (int i = 0; i < 128; i++) model_mem[i] = 'x;
        test_reset();
        test_fill(1'b0, 1'b0, 1'b0, 10'd0);
        test_reads(120);
        test_fill(1'b0, 1'b1, 1'b0, 10'd0);
        test_reads(40);
        test_fill(1'b1, 1'b0, 1'b0, 10'd0);
        test_reads(40);
        test_read_then_start();
        test_reads(40);
        test_reset_mid_fill();
        test_fill(1'b0, 1'b0, 1'b0, 10'd0);
        test_reads(60);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
